led_scan_sequencer: RTL

//  Sequencer that drives the 2-bit select input of the decode24 2-to-4 decoder.

---
 rtl/led_scan_sequencer_pkg.sv | 61 ++++++
 rtl/led_scan_dwell_cnt.sv | 37 +++
 rtl/led_scan_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/led_scan_sequencer_pkg.sv
// Shared types and the position-advance rule for the LED scan sequencer.
// Mode, FSM state and direction encodings live here so every file agrees on them.
package led_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    ModeUp   = 2'b00,
    ModeDown = 2'b01,
    ModePing = 2'b10,
    ModeHold = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StBlank = 2'b10
  } state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  typedef struct packed {
    logic [1:0] pos;
    dir_e       dir;
    logic       wrap;
  } adv_t;

  // One advance of the select. Direction only changes in ping-pong mode.
  function automatic adv_t next_pos(logic [1:0] pos, mode_e mode, dir_e dir);
    adv_t r;
    dir_e d;
    r.pos  = pos;
    r.dir  = dir;
    r.wrap = 1'b0;
    d      = dir;
    case (mode)
      ModeUp: begin
        r.pos  = pos + 2'd1;
        r.wrap = (pos == 2'd3);
      end
      ModeDown: begin
        r.pos  = pos - 2'd1;
        r.wrap = (pos == 2'd0);
      end
      ModePing: begin
        if (pos == 2'd3) begin
          d = DirDown;
        end else if (pos == 2'd0) begin
          d = DirUp;
        end
        r.dir  = d;
        r.pos  = (d == DirUp) ? pos + 2'd1 : pos - 2'd1;
        r.wrap = (pos == 2'd1) && (d == DirDown);
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_scan_dwell_cnt.sv
// Loadable down-counter with a zero flag; times both the dwell and the blank interval.
// Saturates at zero so an unattended count never wraps around.
module led_scan_dwell_cnt
  import led_scan_sequencer_pkg::*;
#(
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/led_scan_sequencer.sv
// Steps the 2-bit decode24 select through positions 0..3 with a programmable dwell.
// Define LED_SCAN_BLANK_EN to blank a_valid for BLANK_CYC cycles after each run advance.
module led_scan_sequencer
  import led_scan_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W   = 24,
  parameter int unsigned DEF_DWELL = 12_000_000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               step,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         a,
  output logic               a_valid,
  output logic               busy,
  output logic               wrap
);

  localparam logic [DWELL_W-1:0] DefLoad = DWELL_W'(DEF_DWELL - 1);
`ifdef LED_SCAN_BLANK_EN
  localparam logic [DWELL_W-1:0] BlankLoad = DWELL_W'(BLANK_CYC - 1);
`endif

  state_e       state_q;
  dir_e         dir_q;
  logic [1:0]   a_q;
  logic         a_valid_q, busy_q, wrap_q;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DWELL_W-1:0] cnt_load_val, dwell_load;
  adv_t               adv;

  assign dwell_load = (dwell == '0) ? DefLoad : dwell - DWELL_W'(1);
  assign adv        = next_pos(a_q, mode_e'(mode), dir_q);

  // Counter is reloaded on every advance; in blank builds that load times the blank first.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = dwell_load;
    unique case (state_q)
      StIdle: cnt_load = start;
      StRun: begin
        cnt_dec  = 1'b1;
        cnt_load = cnt_zero & ~stop;
`ifdef LED_SCAN_BLANK_EN
        cnt_load_val = BlankLoad;
`endif
      end
      StBlank: begin
        cnt_dec  = 1'b1;
        cnt_load = cnt_zero & ~stop;
      end
      default: ;
    endcase
  end

  led_scan_dwell_cnt #(
    .Width(DWELL_W)
  ) u_dwell_cnt (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dir_q     <= DirUp;
      a_q       <= 2'd0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // start has priority over step in the same cycle
          if (start) begin
            state_q   <= StRun;
            busy_q    <= 1'b1;
            a_valid_q <= 1'b1;
          end else if (step) begin
            a_q       <= adv.pos;
            dir_q     <= adv.dir;
            wrap_q    <= adv.wrap;
            a_valid_q <= 1'b1;
          end
        end
        StRun: begin
          if (stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_zero) begin
            a_q    <= adv.pos;
            dir_q  <= adv.dir;
            wrap_q <= adv.wrap;
`ifdef LED_SCAN_BLANK_EN
            state_q   <= StBlank;
            a_valid_q <= 1'b0;
`endif
          end
        end
        StBlank: begin
          if (stop) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            a_valid_q <= 1'b1;
          end else if (cnt_zero) begin
            state_q   <= StRun;
            a_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign busy    = busy_q;
  assign wrap    = wrap_q;

endmodule
